// File: rtl/pdp8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pdp8_pkg
// Brief    : Shared widths, arbiter state/source encodings and defaults.
// Revision : 1.0
// ============================================================================
package pdp8_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;

  localparam int ARB_RD_LAT_DEF     = 1;
  localparam int ARB_STARVE_LIM_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE    = 2'd0,
    SRC_IFU     = 2'd1,
    SRC_EXEC_RD = 2'd2,
    SRC_EXEC_WR = 2'd3
  } arb_src_e;

endpackage
`default_nettype wire

// File: rtl/pdp8_arb_prio.sv
`default_nettype none
// ============================================================================
// Module   : pdp8_arb_prio
// Brief    : Combinational winner select with a saturating fetch-starvation count.
// Revision : 1.0
// ============================================================================
module pdp8_arb_prio
  import pdp8_pkg::*;
#(
  parameter int STARVE_LIM = ARB_STARVE_LIM_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_grant_en,
  input  logic     i_ifu_rd_req,
  input  logic     i_exec_rd_req,
  input  logic     i_exec_wr_req,
  output arb_src_e o_winner
);

  localparam int c_CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [c_CNT_W-1:0] c_LIM = c_CNT_W'(STARVE_LIM);

  logic [c_CNT_W-1:0] r_starve_cnt;
  arb_src_e           w_winner;

  // Fetch overrides exec only once exec has won STARVE_LIM times in a row.
  always_comb begin
    w_winner = SRC_NONE;
    if (i_ifu_rd_req && (r_starve_cnt == c_LIM)) begin
      w_winner = SRC_IFU;
    end else if (i_exec_wr_req) begin
      w_winner = SRC_EXEC_WR;
    end else if (i_exec_rd_req) begin
      w_winner = SRC_EXEC_RD;
    end else if (i_ifu_rd_req) begin
      w_winner = SRC_IFU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (i_grant_en) begin
      case (w_winner)
        SRC_IFU: r_starve_cnt <= '0;
        SRC_EXEC_RD, SRC_EXEC_WR: begin
          if (!i_ifu_rd_req) begin
            r_starve_cnt <= '0;
          end else if (r_starve_cnt != c_LIM) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_winner = w_winner;

endmodule
`default_nettype wire

// File: rtl/pdp8_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pdp8_mem_arbiter
// Brief    : Single-port memory arbiter between instruction fetch and execution.
// Revision : 1.0
// ============================================================================
module pdp8_mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int RD_LAT     = ARB_RD_LAT_DEF,
  parameter int STARVE_LIM = ARB_STARVE_LIM_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic                  ifu_rd_valid,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic                  exec_rd_valid,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_done,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy,
  output logic                  proto_err
);

  localparam logic [2:0] c_RD_LAT = 3'(RD_LAT);

  arb_state_e r_state;
  arb_src_e   r_src;
  logic [2:0] r_lat_cnt;
  arb_src_e   w_winner;
  logic       w_grant_en;

  assign w_grant_en = (r_state == IDLE);

  pdp8_arb_prio #(
    .STARVE_LIM (STARVE_LIM)
  ) u_prio (
    .clk           (clk),
    .rst           (reset),
    .i_grant_en    (w_grant_en),
    .i_ifu_rd_req  (ifu_rd_req),
    .i_exec_rd_req (exec_rd_req),
    .i_exec_wr_req (exec_wr_req),
    .o_winner      (w_winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_src         <= SRC_NONE;
      r_lat_cnt     <= '0;
      ifu_rd_valid  <= 1'b0;
      ifu_rd_data   <= '0;
      exec_rd_valid <= 1'b0;
      exec_rd_data  <= '0;
      exec_wr_done  <= 1'b0;
      mem_rd_req    <= 1'b0;
      mem_wr_req    <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
      busy          <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      mem_rd_req    <= 1'b0;
      mem_wr_req    <= 1'b0;
      ifu_rd_valid  <= 1'b0;
      exec_rd_valid <= 1'b0;
      exec_wr_done  <= 1'b0;

      if ((r_state == IDLE) && exec_rd_req && exec_wr_req) begin
        proto_err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_src <= w_winner;
          case (w_winner)
            SRC_IFU: begin
              mem_addr   <= ifu_rd_addr;
              mem_rd_req <= 1'b1;
              r_lat_cnt  <= c_RD_LAT;
              busy       <= 1'b1;
              r_state    <= RD_WAIT;
            end
            SRC_EXEC_RD: begin
              mem_addr   <= exec_rd_addr;
              mem_rd_req <= 1'b1;
              r_lat_cnt  <= c_RD_LAT;
              busy       <= 1'b1;
              r_state    <= RD_WAIT;
            end
            SRC_EXEC_WR: begin
              mem_addr    <= exec_wr_addr;
              mem_wr_data <= exec_wr_data;
              mem_wr_req  <= 1'b1;
              busy        <= 1'b1;
              r_state     <= WR;
            end
            default: ;
          endcase
        end
        // Count reaches zero in the cycle the memory presents read data.
        RD_WAIT: begin
          if (r_lat_cnt == 3'd0) begin
            if (r_src == SRC_IFU) begin
              ifu_rd_data  <= mem_rd_data;
              ifu_rd_valid <= 1'b1;
            end else begin
              exec_rd_data  <= mem_rd_data;
              exec_rd_valid <= 1'b1;
            end
            r_state <= RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        WR: begin
          exec_wr_done <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          r_src   <= SRC_NONE;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pdp8_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdp8_mem_arbiter
// Brief    : Directed vector bench for the memory arbiter (RD_LAT=1 and RD_LAT=3).
// Revision : 1.0
// ============================================================================
module tb_pdp8_mem_arbiter;

  localparam logic [11:0] A1 = 12'o0100;
  localparam logic [11:0] A2 = 12'o0200;
  localparam logic [11:0] A3 = 12'o0300;
  localparam logic [11:0] D1 = 12'o1234;
  localparam logic [11:0] D2 = 12'o7300;
  localparam logic [11:0] D3 = 12'o5252;
  localparam logic [11:0] D4 = 12'o4321;

  typedef struct packed {
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [11:0] mem_addr;
    logic        ifu_valid;
    logic [11:0] ifu_data;
    logic        erd_valid;
    logic [11:0] erd_data;
    logic        wr_done;
    logic        busy;
    logic        perr;
  } outs_t;

  typedef struct packed {
    logic        ifu;
    logic [11:0] ia;
    logic        erd;
    logic [11:0] ra;
    logic        ewr;
    logic [11:0] wa;
    logic [11:0] wd;
  } ins_t;

  typedef struct packed {
    ins_t  i;
    outs_t o;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // RD_LAT=1 instance
  logic        ifu_rd_req, exec_rd_req, exec_wr_req;
  logic [11:0] ifu_rd_addr, exec_rd_addr, exec_wr_addr, exec_wr_data;
  logic        ifu_rd_valid, exec_rd_valid, exec_wr_done;
  logic [11:0] ifu_rd_data, exec_rd_data;
  logic        mem_rd_req, mem_wr_req, busy, proto_err;
  logic [11:0] mem_addr, mem_wr_data, mem_rd_data;

  // RD_LAT=3 instance, fetch port only
  logic        d3_ifu_rd_req;
  logic [11:0] d3_ifu_rd_addr;
  logic        d3_ifu_rd_valid, d3_exec_rd_valid, d3_exec_wr_done;
  logic [11:0] d3_ifu_rd_data, d3_exec_rd_data;
  logic        d3_mem_rd_req, d3_mem_wr_req, d3_busy, d3_proto_err;
  logic [11:0] d3_mem_addr, d3_mem_wr_data, d3_mem_rd_data;

  pdp8_mem_arbiter #(.RD_LAT(1), .STARVE_LIM(4)) u_dut (
    .clk(clk), .reset(reset),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_valid(ifu_rd_valid), .ifu_rd_data(ifu_rd_data),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
    .exec_rd_valid(exec_rd_valid), .exec_rd_data(exec_rd_data),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr),
    .exec_wr_data(exec_wr_data), .exec_wr_done(exec_wr_done),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .busy(busy), .proto_err(proto_err)
  );

  pdp8_mem_arbiter #(.RD_LAT(3), .STARVE_LIM(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .ifu_rd_req(d3_ifu_rd_req), .ifu_rd_addr(d3_ifu_rd_addr),
    .ifu_rd_valid(d3_ifu_rd_valid), .ifu_rd_data(d3_ifu_rd_data),
    .exec_rd_req(1'b0), .exec_rd_addr(12'o0000),
    .exec_rd_valid(d3_exec_rd_valid), .exec_rd_data(d3_exec_rd_data),
    .exec_wr_req(1'b0), .exec_wr_addr(12'o0000),
    .exec_wr_data(12'o0000), .exec_wr_done(d3_exec_wr_done),
    .mem_rd_req(d3_mem_rd_req), .mem_wr_req(d3_mem_wr_req),
    .mem_addr(d3_mem_addr), .mem_wr_data(d3_mem_wr_data), .mem_rd_data(d3_mem_rd_data),
    .busy(d3_busy), .proto_err(d3_proto_err)
  );

  // Memory models: read data is driven only in the cycle it is valid, zero otherwise.
  logic        pl_en;
  logic [11:0] pl_addr, pl_data;
  logic [11:0] mem1 [0:4095];
  logic [11:0] mem3 [0:4095];
  logic [11:0] mem1_q;
  logic [11:0] mem3_pipe [0:2];

  always @(posedge clk) begin
    if (pl_en) mem1[pl_addr] <= pl_data;
    else if (mem_wr_req) mem1[mem_addr] <= mem_wr_data;
    mem1_q <= mem_rd_req ? mem1[mem_addr] : 12'o0000;
  end
  assign mem_rd_data = mem1_q;

  always @(posedge clk) begin
    if (pl_en) mem3[pl_addr] <= pl_data;
    else if (d3_mem_wr_req) mem3[d3_mem_addr] <= d3_mem_wr_data;
    mem3_pipe[0] <= d3_mem_rd_req ? mem3[d3_mem_addr] : 12'o0000;
    mem3_pipe[1] <= mem3_pipe[0];
    mem3_pipe[2] <= mem3_pipe[1];
  end
  assign d3_mem_rd_data = mem3_pipe[2];

  outs_t got1, got3;
  assign got1 = {mem_rd_req, mem_wr_req, mem_addr, ifu_rd_valid, ifu_rd_data,
                 exec_rd_valid, exec_rd_data, exec_wr_done, busy, proto_err};
  assign got3 = {d3_mem_rd_req, d3_mem_wr_req, d3_mem_addr, d3_ifu_rd_valid, d3_ifu_rd_data,
                 d3_exec_rd_valid, d3_exec_rd_data, d3_exec_wr_done, d3_busy, d3_proto_err};

  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t vecs[$];

  task automatic add(input logic ifu, input logic [11:0] ia, input logic erd, input logic [11:0] ra,
                     input logic ewr, input logic [11:0] wa, input logic [11:0] wd,
                     input logic xrd, input logic xwr, input logic [11:0] xaddr,
                     input logic xiv, input logic [11:0] xid, input logic xev, input logic [11:0] xed,
                     input logic xwd, input logic xbusy, input logic xperr);
    vec_t v;
    v.i = '{ifu: ifu, ia: ia, erd: erd, ra: ra, ewr: ewr, wa: wa, wd: wd};
    v.o = '{mem_rd_req: xrd, mem_wr_req: xwr, mem_addr: xaddr, ifu_valid: xiv, ifu_data: xid,
            erd_valid: xev, erd_data: xed, wr_done: xwd, busy: xbusy, perr: xperr};
    vecs.push_back(v);
  endtask

  task automatic chk_outs(input string name, input outs_t g, input outs_t e);
    n_vec++;
    if (g !== e) begin
      n_miss++;
      $display("FAIL %s: got rd=%b wr=%b addr=%o iv=%b idata=%o ev=%b edata=%o wdone=%b busy=%b perr=%b ; want rd=%b wr=%b addr=%o iv=%b idata=%o ev=%b edata=%o wdone=%b busy=%b perr=%b",
               name, g.mem_rd_req, g.mem_wr_req, g.mem_addr, g.ifu_valid, g.ifu_data, g.erd_valid,
               g.erd_data, g.wr_done, g.busy, g.perr, e.mem_rd_req, e.mem_wr_req, e.mem_addr,
               e.ifu_valid, e.ifu_data, e.erd_valid, e.erd_data, e.wr_done, e.busy, e.perr);
    end
  endtask

  task automatic chk(input string name, input int g, input int e);
    n_vec++;
    if (g !== e) begin
      n_miss++;
      $display("FAIL %s: got %0d (0%o), want %0d (0%o)", name, g, g, e, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ifu_rd_req = 0; ifu_rd_addr = 0; exec_rd_req = 0; exec_rd_addr = 0;
    exec_wr_req = 0; exec_wr_addr = 0; exec_wr_data = 0;
    d3_ifu_rd_req = 0; d3_ifu_rd_addr = 0;
    pl_en = 1'b1; pl_addr = A2; pl_data = D2;

    //     ifu ia   erd ra   ewr wa  wd     rd wr addr iv idata ev edata wd busy perr
    add(1, A2, 0, 0,  0, 0,  0,    0, 0, 0,  0, 0,  0, 0,  0, 0, 0); // reset state
    add(1, A2, 0, 0,  0, 0,  0,    1, 0, A2, 0, 0,  0, 0,  0, 1, 0);
    add(1, A2, 0, 0,  0, 0,  0,    0, 0, A2, 0, 0,  0, 0,  0, 1, 0);
    add(1, A2, 0, 0,  0, 0,  0,    0, 0, A2, 1, D2, 0, 0,  0, 1, 0);
    add(0, 0,  0, 0,  0, 0,  0,    0, 0, A2, 0, D2, 0, 0,  0, 0, 0);
    add(0, 0,  0, 0,  1, A1, D1,   0, 0, A2, 0, D2, 0, 0,  0, 0, 0); // exec write
    add(0, 0,  0, 0,  1, A1, D1,   0, 1, A1, 0, D2, 0, 0,  0, 1, 0);
    add(0, 0,  0, 0,  1, A1, D1,   0, 0, A1, 0, D2, 0, 0,  1, 1, 0);
    add(0, 0,  1, A1, 0, 0,  0,    0, 0, A1, 0, D2, 0, 0,  0, 0, 0); // exec read back
    add(0, 0,  1, A1, 0, 0,  0,    1, 0, A1, 0, D2, 0, 0,  0, 1, 0);
    add(0, 0,  1, A1, 0, 0,  0,    0, 0, A1, 0, D2, 0, 0,  0, 1, 0);
    add(0, 0,  1, A1, 0, 0,  0,    0, 0, A1, 0, D2, 1, D1, 0, 1, 0);
    add(0, 0,  0, 0,  0, 0,  0,    0, 0, A1, 0, D2, 0, D1, 0, 0, 0);
    add(1, A1, 1, A3, 0, 0,  0,    0, 0, A1, 0, D2, 0, D1, 0, 0, 0); // exec vs ifu
    add(1, A1, 1, A3, 0, 0,  0,    1, 0, A3, 0, D2, 0, D1, 0, 1, 0);
    add(1, A1, 1, A3, 0, 0,  0,    0, 0, A3, 0, D2, 0, D1, 0, 1, 0);
    add(1, A1, 1, A3, 0, 0,  0,    0, 0, A3, 0, D2, 1, D3, 0, 1, 0);
    add(1, A1, 0, 0,  0, 0,  0,    0, 0, A3, 0, D2, 0, D3, 0, 0, 0);
    add(1, A1, 0, 0,  0, 0,  0,    1, 0, A1, 0, D2, 0, D3, 0, 1, 0);
    add(1, A1, 0, 0,  0, 0,  0,    0, 0, A1, 0, D2, 0, D3, 0, 1, 0);
    add(1, A1, 0, 0,  0, 0,  0,    0, 0, A1, 1, D1, 0, D3, 0, 1, 0);
    add(0, 0,  0, 0,  0, 0,  0,    0, 0, A1, 0, D1, 0, D3, 0, 0, 0);
    add(0, 0,  1, A1, 1, A3, D4,   0, 0, A1, 0, D1, 0, D3, 0, 0, 0); // rd+wr together
    add(0, 0,  1, A1, 1, A3, D4,   0, 1, A3, 0, D1, 0, D3, 0, 1, 1);
    add(0, 0,  1, A1, 1, A3, D4,   0, 0, A3, 0, D1, 0, D3, 1, 1, 1);
    add(0, 0,  1, A1, 0, 0,  0,    0, 0, A3, 0, D1, 0, D3, 0, 0, 1);
    add(0, 0,  1, A1, 0, 0,  0,    1, 0, A1, 0, D1, 0, D3, 0, 1, 1);
    add(0, 0,  1, A1, 0, 0,  0,    0, 0, A1, 0, D1, 0, D3, 0, 1, 1);
    add(0, 0,  1, A1, 0, 0,  0,    0, 0, A1, 0, D1, 1, D1, 0, 1, 1);
    add(0, 0,  0, 0,  0, 0,  0,    0, 0, A1, 0, D1, 0, D1, 0, 0, 1);
    add(1, A3, 0, 0,  0, 0,  0,    0, 0, A1, 0, D1, 0, D1, 0, 0, 1); // written word visible
    add(1, A3, 0, 0,  0, 0,  0,    1, 0, A3, 0, D1, 0, D1, 0, 1, 1);
    add(1, A3, 0, 0,  0, 0,  0,    0, 0, A3, 0, D1, 0, D1, 0, 1, 1);
    add(1, A3, 0, 0,  0, 0,  0,    0, 0, A3, 1, D4, 0, D1, 0, 1, 1);
    add(0, 0,  0, 0,  0, 0,  0,    0, 0, A3, 0, D4, 0, D1, 0, 0, 1);

    step();
    pl_addr = A3; pl_data = D3;
    step();
    pl_en = 1'b0;
    step();
    reset = 1'b0;

    chk_outs("dut3_reset", got3, '0);

    for (int i = 0; i < vecs.size(); i++) begin
      ifu_rd_req   = vecs[i].i.ifu;
      ifu_rd_addr  = vecs[i].i.ia;
      exec_rd_req  = vecs[i].i.erd;
      exec_rd_addr = vecs[i].i.ra;
      exec_wr_req  = vecs[i].i.ewr;
      exec_wr_addr = vecs[i].i.wa;
      exec_wr_data = vecs[i].i.wd;
      chk_outs($sformatf("vec%0d", i), got1, vecs[i].o);
      step();
    end

    // Starvation: exec and fetch both held high; expect 4 exec grants then 1 fetch.
    begin
      int grants = 0;
      ifu_rd_req = 1'b1;  ifu_rd_addr  = A2;
      exec_rd_req = 1'b1; exec_rd_addr = A1;
      for (int c = 0; c < 80 && grants < 10; c++) begin
        step();
        if (mem_rd_req) begin
          chk($sformatf("starve_grant%0d_addr", grants), int'(mem_addr),
              int'((grants % 5 == 4) ? A2 : A1));
          grants++;
        end
      end
      if (grants < 10) chk("starve_grant_timeout", grants, 10);
      ifu_rd_req = 1'b0;
      exec_rd_req = 1'b0;
      repeat (6) step();
      chk("starve_drain_busy", int'(busy), 0);
    end

    // Reset in RD_WAIT on the RD_LAT=3 instance.
    d3_ifu_rd_req = 1'b1; d3_ifu_rd_addr = A2;
    step();
    chk("d3_mem_rd_req", int'(d3_mem_rd_req), 1);
    step();
    chk("d3_busy_rd_wait", int'(d3_busy), 1);
    reset = 1'b1;
    d3_ifu_rd_req = 1'b0;
    #1;
    chk_outs("d3_in_reset", got3, '0);
    step();
    chk_outs("d3_reset_next", got3, '0);
    chk("dut_perr_cleared", int'(proto_err), 0);
    reset = 1'b0;
    begin
      int spurious = 0;
      for (int c = 0; c < 8; c++) begin
        step();
        if (d3_ifu_rd_valid || d3_busy || d3_mem_rd_req) spurious++;
      end
      chk("d3_no_valid_after_reset", spurious, 0);
    end

    // Fresh request after reset completes with RD_LAT+2 latency.
    begin
      int lat = 0;
      logic seen = 1'b0;
      d3_ifu_rd_req = 1'b1; d3_ifu_rd_addr = A3;
      for (int c = 0; c < 20 && !seen; c++) begin
        step();
        lat++;
        if (d3_ifu_rd_valid) seen = 1'b1;
      end
      d3_ifu_rd_req = 1'b0;
      chk("d3_fresh_latency", seen ? lat : -1, 5);
      chk("d3_fresh_data", int'(d3_ifu_rd_data), int'(D3));
      step();
      chk("d3_fresh_idle", int'(d3_busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
